// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle MSB-first branch comparator/resolver for RV32I-style branches.
// Optional early exit on the first differing chunk when BRCMP_EARLY_EXIT_EN is defined.
module branch_cmp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            eq,
  output logic            lt,
  output logic            taken,
  output logic            illegal
);
  localparam int N  = XLEN / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
`ifdef BRCMP_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_a, r_b, w_flip;
  logic [2:0]      r_f3;
  logic [IW-1:0]   r_idx;
  logic            r_dec, r_lt;
  logic [CHUNK-1:0] w_ca, w_cb;
  logic            w_diff, w_dec, w_lt, w_last, w_eq, w_ill, w_taken;
  // Signed compare becomes unsigned once both sign bits are inverted.
  assign w_flip  = {~funct3[1], {(XLEN-1){1'b0}}};
  assign w_ca    = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_cb    = r_b[int'(r_idx)*CHUNK +: CHUNK];
  assign w_diff  = w_ca != w_cb;
  assign w_dec   = r_dec | w_diff;
  assign w_lt    = r_dec ? r_lt : (w_diff & (w_ca < w_cb));
  assign w_last  = (r_idx == '0) | (EARLY & w_diff);
  assign w_eq    = ~w_dec;
  assign w_ill   = r_f3[2:1] == 2'b01;
  assign w_taken = w_ill ? 1'b0 : r_f3[2] ? (r_f3[0] ^ w_lt) : (r_f3[0] ^ w_eq);
  assign in_ready = r_state == IDLE;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (in_valid ? CMP : IDLE) :
             r_state == CMP  ? (w_last ? DONE : CMP) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_f3      <= '0;
      r_idx     <= '0;
      r_dec     <= 1'b0;
      r_lt      <= 1'b0;
      out_valid <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_a   <= a ^ w_flip;
        r_b   <= b ^ w_flip;
        r_f3  <= funct3;
        r_idx <= IW'(N - 1);
        r_dec <= 1'b0;
        r_lt  <= 1'b0;
      end
      if (r_state == CMP) begin
        r_idx <= r_idx - 1'b1;
        r_dec <= w_dec;
        r_lt  <= w_lt;
        if (w_last) begin
          out_valid <= 1'b1;
          eq        <= w_eq;
          lt        <= w_lt;
          taken     <= w_taken;
          illegal   <= w_ill;
        end
      end
      if (r_state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule
